// File: rtl/inst_fetch_queue_pkg.sv
// Shared widths and defaults for the decoupled instruction-fetch queue.
package inst_fetch_queue_pkg;
    localparam int FQ_INST_W       = 32;
    localparam int FQ_ST_W         = 2;
    localparam int FQ_DEF_ADDR_BIT = 10;
    localparam int FQ_DEF_DEPTH    = 4;
    localparam int FQ_DEF_RESET_PC = 0;

    // Entry layout, MSB first: {inst, pc_4, pred_pc, pred_st}
    function automatic int fq_entry_w(input int addr_bit);
        return FQ_INST_W + 2 * addr_bit + FQ_ST_W;
    endfunction
endpackage

// File: rtl/inst_fetch_queue_fetch_fifo.sv
// fetch_fifo: synchronous DEPTH x W FIFO with flush and occupancy count.
module inst_fetch_queue_fetch_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       push,
    input  logic [W-1:0]               push_data,
    input  logic                       pop,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DEPTH-1:0][W-1:0] mem;
    logic [AW-1:0]           wr_ptr, rd_ptr;

    assign head = mem[rd_ptr];

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem    <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(push) - CW'(pop);
        end
    end

    no_underflow: assert property (@(posedge clk) disable iff (rst)
        !(pop && !flush && count == '0));
    no_overflow: assert property (@(posedge clk) disable iff (rst)
        !(push && !flush && count == CW'(DEPTH)));
endmodule

// File: rtl/inst_fetch_queue.sv
// Decoupled fetch stage: PC, one-deep read credit, skid and end-of-memory stop feeding a FIFO.
// INST_FETCH_BYPASS_EN: an empty FIFO forwards a returning word straight to out_*.
module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int IM_ADDR_BIT = FQ_DEF_ADDR_BIT,
    parameter int DEPTH       = FQ_DEF_DEPTH,
    parameter int RESET_PC    = FQ_DEF_RESET_PC
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic                     redirect_en,
    input  logic [IM_ADDR_BIT-1:0]   redirect_pc,
    input  logic [IM_ADDR_BIT-1:0]   pred_pc,
    input  logic [FQ_ST_W-1:0]       pred_state,
    output logic [IM_ADDR_BIT-1:0]   im_addr,
    output logic                     im_rd_en,
    input  logic [FQ_INST_W-1:0]     im_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [FQ_INST_W-1:0]     out_inst,
    output logic [IM_ADDR_BIT-1:0]   out_pc_4,
    output logic [IM_ADDR_BIT-1:0]   out_pred_pc,
    output logic [FQ_ST_W-1:0]       out_pred_st,
    output logic [$clog2(DEPTH):0]   occupancy
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int EW = fq_entry_w(IM_ADDR_BIT);

    typedef logic [IM_ADDR_BIT-1:0] pc_t;
    typedef struct packed {
        logic [FQ_INST_W-1:0] inst;
        pc_t                  pc_4;
        pc_t                  pred_pc;
        logic [FQ_ST_W-1:0]   st;
    } entry_t;

    pc_t                fetch_pc, meta_pc4, meta_pred;
    logic [FQ_ST_W-1:0] meta_st;
    logic               ret_valid, skid_valid, end_flag;
    entry_t             skid_q, ret_entry, src_entry, head, out_e;
    logic               src_valid, act, byp, push, pop, issue, last_pc;
    logic [CW-1:0]      count;
    logic [CW:0]        used;

    assign last_pc  = &fetch_pc;
    assign used     = {1'b0, count} + (CW+1)'(ret_valid | skid_valid);
    assign issue    = en && !rst && !redirect_en && !end_flag && (used < (CW+1)'(DEPTH));
    assign im_rd_en = issue;
    assign im_addr  = fetch_pc;

    always_comb begin
        ret_entry = '{inst: im_inst, pc_4: meta_pc4, pred_pc: meta_pred, st: meta_st};
        src_valid = ret_valid | skid_valid;
        src_entry = skid_valid ? skid_q : ret_entry;
        act       = en && !redirect_en;
`ifdef INST_FETCH_BYPASS_EN
        byp       = act && src_valid && out_ready && (count == '0);
`else
        byp       = 1'b0;
`endif
        push      = act && src_valid && !byp;
        pop       = act && (count != '0) && out_ready;
        out_valid = (count != '0) || byp;
        out_e     = byp ? src_entry : head;
    end

    assign out_inst    = out_e.inst;
    assign out_pc_4    = out_e.pc_4;
    assign out_pred_pc = out_e.pred_pc;
    assign out_pred_st = out_e.st;
    assign occupancy   = count;

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc   <= pc_t'(RESET_PC);
            meta_pc4   <= '0;
            meta_pred  <= '0;
            meta_st    <= '0;
            ret_valid  <= 1'b0;
            skid_valid <= 1'b0;
            skid_q     <= '0;
            end_flag   <= 1'b0;
        end else if (redirect_en) begin
            fetch_pc   <= redirect_pc;
            ret_valid  <= 1'b0;
            skid_valid <= 1'b0;
            end_flag   <= 1'b0;
        end else if (en) begin
            skid_valid <= 1'b0;
            // The top word's PC+1 wraps to the reserved 0 marker, so its data is dropped.
            ret_valid  <= issue && !last_pc;
            if (issue) begin
                meta_pc4  <= fetch_pc + 1'b1;
                meta_pred <= pred_pc;
                meta_st   <= pred_state;
                fetch_pc  <= pred_pc;
                if (last_pc)
                    end_flag <= 1'b1;
            end
        end else if (ret_valid) begin
            skid_q     <= ret_entry;
            skid_valid <= 1'b1;
            ret_valid  <= 1'b0;
        end
    end

    inst_fetch_queue_fetch_fifo #(.W(EW), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_en),
        .push      (push),
        .push_data (src_entry),
        .pop       (pop),
        .head      (head),
        .count     (count)
    );
endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a program-flow model of the expected instruction stream.
module tb_inst_fetch_queue;
    localparam int AW = 10;
`ifdef INST_FETCH_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    typedef logic [AW-1:0] pc_t;

    logic        clk = 1'b0;
    logic        rst, en, redirect_en, out_ready, im_rd_en, out_valid;
    pc_t         redirect_pc, pred_pc, im_addr, out_pc_4, out_pred_pc;
    logic [1:0]  pred_state, out_pred_st;
    logic [31:0] im_inst, out_inst;
    logic [2:0]  occupancy;

    int  checks = 0;
    int  failures = 0;
    pc_t exp_pc = '0;
    bit  exp_done = 1'b0;
    int  n_acc = 0;
    int  n0;

    always #5 clk = ~clk;

    inst_fetch_queue #(.IM_ADDR_BIT(AW), .DEPTH(4), .RESET_PC(0)) dut (
        .clk(clk), .rst(rst), .en(en), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .pred_pc(pred_pc), .pred_state(pred_state), .im_addr(im_addr), .im_rd_en(im_rd_en),
        .im_inst(im_inst), .out_valid(out_valid), .out_ready(out_ready), .out_inst(out_inst),
        .out_pc_4(out_pc_4), .out_pred_pc(out_pred_pc), .out_pred_st(out_pred_st),
        .occupancy(occupancy)
    );

    // Predictor: one taken branch 0x05 -> 0x20, everything else falls through.
    function automatic pc_t pred_of(input pc_t a);
        return (a == pc_t'(5)) ? pc_t'(32) : pc_t'(a + 1'b1);
    endfunction
    function automatic logic [1:0] st_of(input pc_t a);
        return a[1:0] ^ 2'b10;
    endfunction

    always_comb begin
        pred_pc    = pred_of(im_addr);
        pred_state = st_of(im_addr);
    end

    // Instruction memory: word[i] = i, one-cycle read latency.
    always @(posedge clk)
        if (im_rd_en) im_inst <= {22'd0, im_addr};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask
    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic wait_head(input string name, input pc_t pc4);
        int k = 0;
        at_neg();
        while (!(out_valid && out_pc_4 == pc4) && k < 20) begin
            tick(); at_neg(); k++;
        end
        chk(name, 32'(k < 20), 1);
    endtask

    // Stream model: from the last reset/redirect target, entries follow the predictor
    // until PC 0x3FF, whose entry (PC+1 = 0) is never delivered.
    always @(negedge clk) begin
        if (rst) begin
            exp_pc = '0; exp_done = 1'b0;
        end else if (redirect_en) begin
            exp_pc = redirect_pc; exp_done = (redirect_pc == '1);
        end else begin
            if (exp_done) chk("stream_end_valid", 32'(out_valid), 0);
            else if (out_valid) begin
                chk("m_inst", out_inst, {22'd0, exp_pc});
                chk("m_pc4", 32'(out_pc_4), 32'(pc_t'(exp_pc + 1'b1)));
                chk("m_pred", 32'(out_pred_pc), 32'(pred_of(exp_pc)));
                chk("m_st", 32'(out_pred_st), 32'(st_of(exp_pc)));
                if (out_ready && en) begin
                    n_acc++;
                    exp_pc = pred_of(exp_pc);
                    if (exp_pc == '1) exp_done = 1'b1;
                end
            end
            chk("occ_bound", 32'(occupancy <= 3'd4), 1);
        end
    end

    initial begin
        int k;
        rst = 1'b1; en = 1'b1; redirect_en = 1'b0; redirect_pc = '0; out_ready = 1'b1;
        tick(); tick();
        at_neg();
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_occ", 32'(occupancy), 0);
        chk("rst_rd_en", 32'(im_rd_en), 0);
        chk("rst_inst", out_inst, 0);
        chk("rst_pc4", 32'(out_pc_4), 0);
        chk("rst_meta", {20'd0, out_pred_st, out_pred_pc}, 0);

        // Streaming from reset, one word per cycle
        tick(); rst = 1'b0;
        for (int c = 0; c < 5; c++) begin
            at_neg();
            chk("lat_addr", 32'(im_addr), c);
            chk("lat_valid", 32'(out_valid), 32'(c >= LAT));
            if (c >= LAT) begin
                chk("lat_pc4", 32'(out_pc_4), c - LAT + 1);
                chk("lat_inst", out_inst, c - LAT);
            end
            tick();
        end

        // Predicted jump 0x05 -> 0x20
        at_neg(); chk("jmp_from", 32'(im_addr), 5);
        tick(); at_neg();
        chk("jmp_to", 32'(im_addr), 32'h20);
        chk("jmp_rd_en", 32'(im_rd_en), 1);
        wait_head("jmp_head_timeout", pc_t'(6));
        chk("jmp_pred", 32'(out_pred_pc), 32'h20);
        chk("jmp_st", 32'(out_pred_st), 3);
        chk("jmp_inst", out_inst, 5);
        tick(); at_neg(); chk("jmp_next_pc4", 32'(out_pc_4), 32'h21);

        // Decode stall fills the queue and stops issue
        tick(); out_ready = 1'b0;
        repeat (10) tick();
        at_neg();
        chk("full_occ", 32'(occupancy), 4);
        chk("full_rd_en", 32'(im_rd_en), 0);
        chk("full_valid", 32'(out_valid), 1);
        tick(); out_ready = 1'b1;
        repeat (8) tick();

        // Redirect with three queued and one in flight
        out_ready = 1'b0;
        k = 0; at_neg();
        while (occupancy != 3'd2 && k < 20) begin tick(); at_neg(); k++; end
        chk("fill_timeout", 32'(k < 20), 1);
        tick(); redirect_en = 1'b1; redirect_pc = pc_t'(32'h40);
        at_neg();
        chk("redir_occ", 32'(occupancy), 3);
        chk("redir_rd_en", 32'(im_rd_en), 0);
        tick(); redirect_en = 1'b0; out_ready = 1'b1;
        at_neg();
        chk("redir_valid", 32'(out_valid), 0);
        chk("redir_addr", 32'(im_addr), 32'h40);
        chk("redir_issue", 32'(im_rd_en), 1);
        chk("redir_flush", 32'(occupancy), 0);
        wait_head("redir_head_timeout", pc_t'(32'h41));
        chk("redir_inst", out_inst, 32'h40);
        repeat (4) tick();

        // Enable drops the cycle after an issue: the response goes to the skid
        redirect_en = 1'b1; redirect_pc = pc_t'(32'h80);
        tick(); redirect_en = 1'b0;
        at_neg();
        chk("skid_issue", 32'(im_rd_en), 1);
        chk("skid_addr", 32'(im_addr), 32'h80);
        tick(); en = 1'b0;
        at_neg();
        chk("skid_rd_off", 32'(im_rd_en), 0);
        chk("skid_valid0", 32'(out_valid), 0);
        tick(); at_neg();
        chk("skid_hold_occ", 32'(occupancy), 0);
        tick(); en = 1'b1;
        at_neg();
`ifdef INST_FETCH_BYPASS_EN
        chk("skid_byp_valid", 32'(out_valid), 1);
        chk("skid_byp_pc4", 32'(out_pc_4), 32'h81);
        tick(); at_neg();
        chk("skid_next_pc4", 32'(out_pc_4), 32'h82);
`else
        chk("skid_push_valid", 32'(out_valid), 0);
        chk("skid_next_addr", 32'(im_addr), 32'h81);
        tick(); at_neg();
        chk("skid_out_valid", 32'(out_valid), 1);
        chk("skid_out_pc4", 32'(out_pc_4), 32'h81);
        chk("skid_out_inst", out_inst, 32'h80);
`endif
        repeat (5) tick();

        // End of memory: 0x3FC..0x3FE delivered, 0x3FF dropped, issue stops
        redirect_en = 1'b1; redirect_pc = pc_t'(32'h3FC);
        tick(); redirect_en = 1'b0; n0 = n_acc;
        repeat (8) tick();
        at_neg();
        chk("end_valid", 32'(out_valid), 0);
        chk("end_rd_en", 32'(im_rd_en), 0);
        chk("end_occ", 32'(occupancy), 0);
        chk("end_count", n_acc - n0, 3);
        for (int c = 0; c < 4; c++) begin
            tick(); at_neg(); chk("end_stuck", 32'(im_rd_en), 0);
        end
        tick(); redirect_en = 1'b1; redirect_pc = pc_t'(32'h10);
        tick(); redirect_en = 1'b0;
        at_neg();
        chk("end_resume_rd", 32'(im_rd_en), 1);
        chk("end_resume_addr", 32'(im_addr), 32'h10);
        repeat (6) tick();

        // Reset mid-stream discards everything
        rst = 1'b1;
        tick(); at_neg();
        chk("mrst_valid", 32'(out_valid), 0);
        chk("mrst_occ", 32'(occupancy), 0);
        chk("mrst_rd_en", 32'(im_rd_en), 0);
        chk("mrst_pc4", 32'(out_pc_4), 0);
        chk("mrst_inst", out_inst, 0);
        tick(); rst = 1'b0;
        wait_head("mrst_head_timeout", pc_t'(1));
        chk("mrst_first_inst", out_inst, 0);
        repeat (4) tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
